// File: rtl/dbg_frame_serializer_pkg.sv
// Shared definitions for the debug frame serializer: FSM state encodings,
// default header byte and byte-lane geometry of a debug word.
package dbg_frame_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] DBG_HDR_BYTE   = 8'h42;
  localparam int         DBG_WORD_BYTES = 4;
  localparam int         BYTE_IDX_W     = 2;

  // Index width that stays legal (>=1 bit) even for a single-word frame.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbg_byte_mux.sv
// Combinational byte selector: picks byte i_byte_idx of word i_word_idx
// out of the flattened snapshot register.
module dbg_byte_mux
  import dbg_frame_serializer_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int WIW       = idx_width(NUM_WORDS)
) (
  input  logic [NUM_WORDS*32-1:0] i_snapshot,
  input  logic [WIW-1:0]          i_word_idx,
  input  logic [BYTE_IDX_W-1:0]   i_byte_idx,
  output logic [7:0]              o_byte
);

  logic [31:0] w_words [NUM_WORDS];
  logic [31:0] w_sel;

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign w_words[gi] = i_snapshot[32*gi +: 32];
    end
  endgenerate

  assign w_sel = w_words[i_word_idx];

  // Byte 0 is the least significant byte, so it goes out first.
  always_comb begin
    o_byte = 8'h00;
    case (i_byte_idx)
      2'd0: o_byte = w_sel[7:0];
      2'd1: o_byte = w_sel[15:8];
      2'd2: o_byte = w_sel[23:16];
      2'd3: o_byte = w_sel[31:24];
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/dbg_frame_serializer.sv
// Snapshots NUM_WORDS debug words on start and streams header + data bytes
// into the UART TX FIFO. Optional trailing XOR checksum byte: DBG_CHECKSUM_EN.
module dbg_frame_serializer
  import dbg_frame_serializer_pkg::*;
#(
  parameter int         NUM_WORDS = 8,
  parameter logic [7:0] HDR_BYTE  = DBG_HDR_BYTE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_WORDS*32-1:0] words,
  input  logic                    fifo_full,
  output logic [7:0]              fifo_din,
  output logic                    fifo_wr_en,
  output logic                    busy,
  output logic                    done
);

  localparam int             WIW       = idx_width(NUM_WORDS);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(NUM_WORDS - 1);

  state_t                  r_state;
  logic [NUM_WORDS*32-1:0] r_snapshot;
  logic [WIW-1:0]          r_word_idx;
  logic [BYTE_IDX_W-1:0]   r_byte_idx;
  logic                    r_busy;
  logic                    r_done;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]              r_csum;
`endif

  logic       w_sending;
  logic       w_wr_en;
  logic [7:0] w_data_byte;
  logic [7:0] w_din;

  dbg_byte_mux #(
    .NUM_WORDS (NUM_WORDS),
    .WIW       (WIW)
  ) u_byte_mux (
    .i_snapshot (r_snapshot),
    .i_word_idx (r_word_idx),
    .i_byte_idx (r_byte_idx),
    .o_byte     (w_data_byte)
  );

  always_comb begin
    w_sending = 1'b0;
    w_din     = 8'h00;
    case (r_state)
      ST_HDR: begin
        w_sending = 1'b1;
        w_din     = HDR_BYTE;
      end
      ST_DATA: begin
        w_sending = 1'b1;
        w_din     = w_data_byte;
      end
`ifdef DBG_CHECKSUM_EN
      ST_CSUM: begin
        w_sending = 1'b1;
        w_din     = r_csum;
      end
`endif
      default: ;
    endcase
  end

  // A full FIFO simply withholds the strobe; the FSM only moves on a real write.
  assign w_wr_en = w_sending && !fifo_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_snapshot <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DBG_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_snapshot <= words;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
`ifdef DBG_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
            r_state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_wr_en) begin
`ifdef DBG_CHECKSUM_EN
            r_csum  <= r_csum ^ w_din;
`endif
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_wr_en) begin
`ifdef DBG_CHECKSUM_EN
            r_csum <= r_csum ^ w_din;
`endif
            if (r_byte_idx == 2'd3) begin
              r_byte_idx <= '0;
              if (r_word_idx == LAST_WORD) begin
                r_word_idx <= '0;
`ifdef DBG_CHECKSUM_EN
                r_state    <= ST_CSUM;
`else
                r_state    <= ST_DONE;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
`endif
              end else begin
                r_word_idx <= r_word_idx + 1'b1;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
        end
`ifdef DBG_CHECKSUM_EN
        ST_CSUM: begin
          if (w_wr_en) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_din   = w_din;
  assign fifo_wr_en = w_wr_en;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_dbg_frame_serializer.sv
// Directed bench for dbg_frame_serializer: a 2-word instance for the basic,
// stall, re-start and reset cases, and a 64-word instance for back-to-back frames.
module tb_dbg_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_a, full_a, start_b, full_b;
  logic [63:0]   words_a;
  logic [2047:0] words_b;
  logic [7:0]    din_a, din_b;
  logic          wr_a, wr_b, busy_a, busy_b, done_a, done_b;

  dbg_frame_serializer #(.NUM_WORDS(2), .HDR_BYTE(8'h42)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .words(words_a), .fifo_full(full_a),
    .fifo_din(din_a), .fifo_wr_en(wr_a), .busy(busy_a), .done(done_a)
  );

  dbg_frame_serializer #(.NUM_WORDS(64), .HDR_BYTE(8'h42)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .words(words_b), .fifo_full(full_b),
    .fifo_din(din_b), .fifo_wr_en(wr_b), .busy(busy_b), .done(done_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap_a[$], cap_b[$], exp_q[$];
  int         wc_a[$], wc_b[$];
  int         done_cyc_a = -1, done_cyc_b = -1;
  bit         done_seen_a = 0, done_seen_b = 0;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_a) begin cap_a.push_back(din_a); wc_a.push_back(cyc); end
    if (wr_b) begin cap_b.push_back(din_b); wc_b.push_back(cyc); end
    if (done_a) begin done_seen_a = 1; done_cyc_a = cyc; end
    if (done_b) begin done_seen_b = 1; done_cyc_b = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input logic [2047:0] w, input int nw);
`ifdef DBG_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h42;
`endif
    exp_q.delete();
    exp_q.push_back(8'h42);
    for (int k = 0; k < nw; k++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[32*k + 8*b +: 8]);
`ifdef DBG_CHECKSUM_EN
        cs = cs ^ w[32*k + 8*b +: 8];
`endif
      end
    end
`ifdef DBG_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic start_a_pulse(output int s);
    cap_a.delete();
    wc_a.delete();
    done_seen_a = 0;
    start_a = 1'b1;
    s = cyc;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n = 0;
    while (!done_seen_a && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_seen_a), 32'd1);
  endtask

  task automatic wait_done_b(input string tag, input int budget);
    int n = 0;
    while (!done_seen_b && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_seen_b), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int s, input int stall);
    int n;
    n = cap_a.size();
    check({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), cap_a[i], exp_q[i]);
    if (n > 0) begin
      check({tag, "_first_cyc"}, wc_a[0], s + 1);
      check({tag, "_span"}, wc_a[n-1] - wc_a[0], exp_q.size() - 1 + stall);
      check({tag, "_done_cyc"}, done_cyc_a, wc_a[n-1] + 1);
    end
    $display("frame %s: %0d bytes written, done at cycle %0d", tag, n, done_cyc_a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    t1_bytes [9];
    logic [63:0]   w_orig;
    logic [2047:0] wb1, wb2;
    int s, n_before, d1, len_b;

    t1_bytes = '{8'h42, 8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89};
    w_orig   = {32'h89ABCDEF, 32'h01234567};

    rst_n = 1'b0; start_a = 1'b0; full_a = 1'b0; start_b = 1'b0; full_b = 1'b0;
    words_a = '0; words_b = '0;
    repeat (3) tick();
    @(negedge clk); #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_wr_en", wr_a, 1'b0);
    check("rst_din", din_a, 8'h00);
    check("rst_busy_b", busy_b, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: basic frame, hand-computed byte sequence
    exp_q.delete();
    foreach (t1_bytes[i]) exp_q.push_back(t1_bytes[i]);
`ifdef DBG_CHECKSUM_EN
    exp_q.push_back(8'h42);
`endif
    words_a = w_orig;
    start_a_pulse(s);
    @(negedge clk); #1;
    check("t1_busy", busy_a, 1'b1);
    wait_done_a("t1", 40);
    @(negedge clk); #1;
    check("t1_busy_after", busy_a, 1'b0);
    check("t1_done_one_cycle", done_a, 1'b0);
    check_frame("t1", s, 0);
    tick();

    // 2: three stalled cycles while byte 23 is pending
    build_exp({1984'd0, w_orig}, 2);
    start_a_pulse(s);
    tick(); tick(); tick();
    full_a = 1'b1;
    @(negedge clk); #1;
    check("t2_wr_during_full", wr_a, 1'b0);
    tick(); tick(); tick();
    full_a = 1'b0;
    wait_done_a("t2", 40);
    if (wc_a.size() > 3) check("t2_byte23_cyc", wc_a[3], s + 7);
    check_frame("t2", s, 3);
    tick();

    // 3: start while busy with new words, then start during DONE
    build_exp({1984'd0, w_orig}, 2);
    start_a_pulse(s);
    tick(); tick(); tick();
    words_a = 64'hDEADBEEF_CAFEF00D;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a("t3", 40);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    check("t3_idle_after_done", busy_a, 1'b0);
    check_frame("t3", s, 0);

    // 4: reset in the middle of DATA, then a fresh frame
    words_a = w_orig;
    start_a_pulse(s);
    tick(); tick();
    @(negedge clk); #1;
    check("t4_busy_pre", busy_a, 1'b1);
    rst_n = 1'b0;
    n_before = cap_a.size();
    tick();
    @(negedge clk); #1;
    check("t4_rst_busy", busy_a, 1'b0);
    check("t4_rst_wr_en", wr_a, 1'b0);
    check("t4_rst_din", din_a, 8'h00);
    rst_n = 1'b1;
    repeat (5) tick();
    check("t4_no_writes_after_rst", cap_a.size(), n_before);
    words_a = 64'h0BADF00D_76543210;
    build_exp({1984'd0, words_a}, 2);
    start_a_pulse(s);
    wait_done_a("t4", 40);
    check_frame("t4", s, 0);

    // 6: 64-word frames, second start on the cycle after done
    for (int k = 0; k < 64; k++)
      wb1[32*k +: 32] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    wb2 = ~wb1;
    words_b = wb1;
    cap_b.delete(); wc_b.delete();
    tick();
    done_seen_b = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done_b("t6a", 400);
    d1 = done_cyc_b;
    words_b = wb2;
    done_seen_b = 0;
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done_b("t6b", 400);
    build_exp(wb1, 64);
    len_b = exp_q.size();
    check("t6_len", cap_b.size(), 2 * len_b);
    for (int i = 0; i < len_b && i < cap_b.size(); i++)
      check($sformatf("t6a_byte%0d", i), cap_b[i], exp_q[i]);
    build_exp(wb2, 64);
    for (int i = 0; i < len_b && len_b + i < cap_b.size(); i++)
      check($sformatf("t6b_byte%0d", i), cap_b[len_b + i], exp_q[i]);
    if (cap_b.size() == 2 * len_b) begin
      check("t6a_span", wc_b[len_b-1] - wc_b[0], len_b - 1);
      check("t6b_span", wc_b[2*len_b-1] - wc_b[len_b], len_b - 1);
      check("t6b_hdr_cyc", wc_b[len_b], d1 + 2);
      check("t6b_done_cyc", done_cyc_b, wc_b[2*len_b-1] + 1);
    end
    $display("frame t6: %0d bytes written over two frames, done at cycle %0d", cap_b.size(), done_cyc_b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
